// File: rtl/pwm_gate_pkg.sv
// Shared types and helpers for the half-bridge gate driver.
// Optional min-on hold is enabled with `define PWM_GATE_MIN_ON_EN.
package pwm_gate_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DT_H  = 3'd1,
    HI    = 3'd2,
    DT_L  = 3'd3,
    LO    = 3'd4,
    FAULT = 3'd5
  } gate_state_t;

  // A zero dead time still yields one cycle with both gates off.
  function automatic int unsigned dt_eff(input int unsigned d);
    return (d == 0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/pwm_gate_driver_dly_cnt.sv
// Loadable down-counter; done flags the final cycle of a loaded interval.
module dly_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count <= W'(1));

endmodule

// File: rtl/pwm_gate_driver.sv
// Complementary gate drive for one half-bridge leg with dead time and latched fault.
// Build option: `define PWM_GATE_MIN_ON_EN adds a MIN_ON-cycle hold in HI/LO.
module pwm_gate_driver
  import pwm_gate_pkg::*;
#(
  parameter int DTW    = 8,
  parameter int MIN_ON = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           pwm,
  input  logic [DTW-1:0] dt,
  input  logic           fault,
  input  logic           clr_fault,
  output logic           gate_hi,
  output logic           gate_lo,
  output logic           faulted,
  output logic           dead,
  output gate_state_t    state
);

  gate_state_t nxt;
  logic        dt_load;
  logic        dt_done;
  logic        hold_done;

  assign dt_load = ((nxt == DT_H) || (nxt == DT_L)) && (nxt != state);

  dly_cnt #(.W(DTW)) u_dead (
    .clk   (clk),
    .rst   (rst),
    .load  (dt_load),
    .value (DTW'(dt_eff(32'(dt)))),
    .done  (dt_done)
  );

`ifdef PWM_GATE_MIN_ON_EN
  localparam int HW = $clog2(MIN_ON + 1);
  logic hold_load;

  assign hold_load = ((nxt == HI) || (nxt == LO)) && (nxt != state);

  dly_cnt #(.W(HW)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load),
    .value (HW'(MIN_ON)),
    .done  (hold_done)
  );
`else
  assign hold_done = 1'b1;
`endif

  // Fault and disable override everything except reset; FAULT ignores en.
  always_comb begin
    nxt = state;
    if ((state != FAULT) && fault) begin
      nxt = FAULT;
    end else if ((state != FAULT) && !en) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:  nxt = pwm ? DT_H : DT_L;
        DT_H: begin
          if (dt_done)   nxt = HI;
          else if (!pwm) nxt = LO;
        end
        HI:    if (!pwm && hold_done) nxt = DT_L;
        DT_L: begin
          if (dt_done)  nxt = LO;
          else if (pwm) nxt = HI;
        end
        LO:    if (pwm && hold_done) nxt = DT_H;
        FAULT: if (clr_fault && !fault) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
      faulted <= 1'b0;
      dead    <= 1'b0;
    end else begin
      state   <= nxt;
      gate_hi <= (nxt == HI);
      gate_lo <= (nxt == LO);
      faulted <= (nxt == FAULT);
      dead    <= (nxt == DT_H) || (nxt == DT_L);
    end
  end

endmodule

// File: tb/tb_pwm_gate_driver.sv
// Directed bench for pwm_gate_driver: dead time, abort, fault, enable and reset paths.
module tb_pwm_gate_driver;
  import pwm_gate_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        pwm = 1'b0;
  logic [7:0]  dt = 8'd3;
  logic        fault = 1'b0;
  logic        clr_fault = 1'b0;
  logic        gate_hi, gate_lo, faulted, dead;
  gate_state_t state;

  int n_checks = 0;
  int n_pass   = 0;
  bit running  = 1'b1;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  pwm_gate_driver #(.DTW(8), .MIN_ON(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm       (pwm),
    .dt        (dt),
    .fault     (fault),
    .clr_fault (clr_fault),
    .gate_hi   (gate_hi),
    .gate_lo   (gate_lo),
    .faulted   (faulted),
    .dead      (dead),
    .state     (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic hi, input logic lo,
                            input logic flt, input logic dd);
    check({tag, "_hi"}, 32'(gate_hi), 32'(hi));
    check({tag, "_lo"}, 32'(gate_lo), 32'(lo));
    check({tag, "_flt"}, 32'(faulted), 32'(flt));
    check({tag, "_dead"}, 32'(dead), 32'(dd));
  endtask

  // Steps until the target gate turns on; counts the cycles spent with both gates off.
  task automatic wait_gate(input string tag, input logic to_hi, input int exp_len);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (to_hi ? gate_hi : gate_lo) begin
        hit = 1'b1;
        break;
      end
      check({tag, "_other"}, 32'(to_hi ? gate_lo : gate_hi), 32'd0);
      check({tag, "_dead"}, 32'(dead), 32'd1);
      n++;
    end
    check({tag, "_reached"}, 32'(hit), 32'd1);
    check({tag, "_len"}, 32'(n), 32'(exp_len));
  endtask

  task automatic hold_gate(input string tag, input logic to_hi, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      check(tag, 32'({gate_hi, gate_lo}), to_hi ? 32'd2 : 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (running) check("excl", 32'(gate_hi & gate_lo), 32'd0);
  end

  initial begin
    // reset
    step();
    step();
    check_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    step();
    check_outs("idle_dis", 1'b0, 1'b0, 1'b0, 1'b0);

    // dt=3 toggling every 20 cycles
    en = 1'b1;
    pwm = 1'b0;
    wait_gate("dt3_lo0", 1'b0, 3);
    hold_gate("dt3_hold_lo", 1'b0, 16);
    for (int k = 0; k < 2; k++) begin
      pwm = 1'b1;
      wait_gate("dt3_hi", 1'b1, 3);
      hold_gate("dt3_hold_hi", 1'b1, 16);
      pwm = 1'b0;
      wait_gate("dt3_lo", 1'b0, 3);
      hold_gate("dt3_hold_lo", 1'b0, 16);
    end

    // dt=0 gives one dead cycle
    dt = 8'd0;
    pwm = 1'b1;
    wait_gate("dt0", 1'b1, 1);
    hold_gate("dt0_hold", 1'b1, 3);

    // dt=255 full-width interval
    dt = 8'd255;
    pwm = 1'b0;
    wait_gate("dt255", 1'b0, 255);
    hold_gate("dt255_hold", 1'b0, 3);

    // dt change mid-interval is ignored
    dt = 8'd5;
    pwm = 1'b1;
    step();
    check("dtchg_dead", 32'(dead), 32'd1);
    dt = 8'd1;
    wait_gate("dtchg", 1'b1, 4);
    hold_gate("dtchg_hold", 1'b1, 5);

    // settle in LO, then short pwm pulse aborts DT_H
    dt = 8'd3;
    pwm = 1'b0;
    wait_gate("pre_abort", 1'b0, 3);
    hold_gate("pre_abort_hold", 1'b0, 6);
    dt = 8'd5;
    pwm = 1'b1;
    step();
    check_outs("abort_e0", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("abort_e1", 1'b0, 1'b0, 1'b0, 1'b1);
    pwm = 1'b0;
    step();
    check_outs("abort_e2", 1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_state", 32'(state), 32'(LO));
    hold_gate("abort_hold", 1'b0, 6);

    // dt=3, one-cycle pulse also aborts in DT_H
    dt = 8'd3;
    pwm = 1'b1;
    step();
    pwm = 1'b0;
    step();
    check_outs("pulse3", 1'b0, 1'b1, 1'b0, 1'b0);
    hold_gate("pulse3_hold", 1'b0, 6);

    // dt=0, one-cycle pulse: completion wins, then min-on hold if built in
    dt = 8'd0;
    exp_q.push_back(2'b00);
`ifdef PWM_GATE_MIN_ON_EN
    repeat (4) exp_q.push_back(2'b10);
`else
    exp_q.push_back(2'b10);
`endif
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    pwm = 1'b1;
    step();
    pwm = 1'b0;
    check("pulse0_e0", 32'({gate_hi, gate_lo}), 32'(exp_q.pop_front()));
    while (exp_q.size() > 0) begin
      step();
      check("pulse0_seq", 32'({gate_hi, gate_lo}), 32'(exp_q.pop_front()));
    end

    // fault while in HI
    dt = 8'd3;
    pwm = 1'b1;
    wait_gate("pre_fault", 1'b1, 3);
    hold_gate("pre_fault_hold", 1'b1, 5);
    fault = 1'b1;
    step();
    check_outs("fault_in", 1'b0, 1'b0, 1'b1, 1'b0);
    check("fault_state", 32'(state), 32'(FAULT));
    clr_fault = 1'b1;
    step();
    check_outs("clr_blocked", 1'b0, 1'b0, 1'b1, 1'b0);
    clr_fault = 1'b0;
    fault = 1'b0;
    step();
    check_outs("clr_not_held", 1'b0, 1'b0, 1'b1, 1'b0);
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    check_outs("clr_ok", 1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_state", 32'(state), 32'(IDLE));
    wait_gate("post_fault", 1'b1, 3);
    hold_gate("post_fault_hold", 1'b1, 3);

    // enable drop
    en = 1'b0;
    step();
    check_outs("en_off", 1'b0, 1'b0, 1'b0, 1'b0);
    check("en_off_state", 32'(state), 32'(IDLE));
    en = 1'b1;
    wait_gate("en_on", 1'b1, 3);

    // reset while in LO
    pwm = 1'b0;
    wait_gate("pre_rst_lo", 1'b0, 3);
    hold_gate("pre_rst_lo_hold", 1'b0, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs("rst_lo", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_lo_state", 32'(state), 32'(IDLE));
    wait_gate("rst_lo_restart", 1'b0, 3);
    hold_gate("rst_lo_restart_hold", 1'b0, 5);

    // reset while in DT_H
    pwm = 1'b1;
    step();
    check("pre_rst_dth", 32'(state), 32'(DT_H));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs("rst_dth", 1'b0, 1'b0, 1'b0, 1'b0);
    wait_gate("rst_dth_restart", 1'b1, 3);
    hold_gate("rst_dth_restart_hold", 1'b1, 3);

    running = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
